// File: rtl/alu_pkg.sv
// Shared definitions for the iterative ALU: control codes, FSM encoding,
// and the legal operand width range.
package alu_pkg;

  localparam int XLEN_MIN = 8;
  localparam int XLEN_MAX = 64;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_MUL = 4'b0111;
  localparam logic [3:0] ALU_DIV = 4'b0100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multi-cycle datapath: a shift-add multiply step and a
// restoring-division step. Purely combinational; the caller owns the shifts
// of the multiplicand, multiplier and quotient registers.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] mcand,
  input  logic            mplier_lsb,
  output logic [XLEN-1:0] acc_nxt,
  input  logic [XLEN-1:0] rem,
  input  logic            dvnd_msb,
  input  logic [XLEN-1:0] dvsr,
  output logic [XLEN-1:0] rem_nxt,
  output logic            q_bit
);

  logic [XLEN:0] rem_sh;

  // Add the shifted multiplicand when the current multiplier bit is set;
  // bring in the next dividend bit and subtract only if it fits.
  always_comb begin
    acc_nxt = mplier_lsb ? acc + mcand : acc;
    rem_sh  = {rem, dvnd_msb};
    q_bit   = (rem_sh >= {1'b0, dvsr});
    // Both candidates are below the divisor, so they fit in XLEN bits.
    rem_nxt = q_bit ? XLEN'(rem_sh - {1'b0, dvsr}) : XLEN'(rem_sh);
  end

endmodule

// File: rtl/iterative_alu.sv
// Iterative ALU: logic/add/sub finish at the accepting edge, MUL and signed
// DIV take XLEN one-bit iterations in BUSY. Results are registered and held.
module iterative_alu
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] alu_ctrl,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic [XLEN-1:0]   result,
  output logic              done,
  output logic              zero,
  output logic              illegal
);

  localparam int CNT_W = $clog2(XLEN) + 1;

  state_e           state, state_nxt;
  logic             accept, multi, last;
  logic             is_and, is_or, is_add, is_sub, is_mul, is_div_op, div_by_zero;
  logic [XLEN-1:0]  fast_res;
  logic             fast_ill;
  logic [XLEN-1:0]  a_mag, b_mag;

  // iteration state
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  mcand, mplier, acc;
  logic [XLEN-1:0]  rem, quo, dvsr;
  logic             neg, is_div;

  logic [XLEN-1:0]  acc_nxt, rem_nxt, quo_nxt, div_res, fin_res;
  logic             q_bit;

  assign is_and      = (alu_ctrl == CTRL_W'(ALU_AND));
  assign is_or       = (alu_ctrl == CTRL_W'(ALU_OR));
  assign is_add      = (alu_ctrl == CTRL_W'(ALU_ADD));
  assign is_sub      = (alu_ctrl == CTRL_W'(ALU_SUB));
  assign is_mul      = (alu_ctrl == CTRL_W'(ALU_MUL));
  assign is_div_op   = (alu_ctrl == CTRL_W'(ALU_DIV));
  assign div_by_zero = (op_b == '0);

  // Divide-by-zero short-circuits to all-ones without iterating.
  assign multi  = is_mul | (is_div_op & ~div_by_zero);
  assign accept = in_valid & in_ready;
  assign last   = (state == ST_BUSY) && (cnt == CNT_W'(XLEN - 1));

  // Magnitudes for restoring division; the most negative value maps to
  // 2^(XLEN-1), which still fits unsigned in XLEN bits.
  assign a_mag = op_a[XLEN-1] ? -op_a : op_a;
  assign b_mag = op_b[XLEN-1] ? -op_b : op_b;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier_lsb (mplier[0]),
    .acc_nxt    (acc_nxt),
    .rem        (rem),
    .dvnd_msb   (quo[XLEN-1]),
    .dvsr       (dvsr),
    .rem_nxt    (rem_nxt),
    .q_bit      (q_bit)
  );

  assign quo_nxt = {quo[XLEN-2:0], q_bit};
  assign div_res = neg ? -quo_nxt : quo_nxt;
  assign fin_res = is_div ? div_res : acc_nxt;

  // Single-cycle result and illegal flag for the current request.
  always_comb begin
    fast_res = '0;
    fast_ill = 1'b0;
    if (is_and)         fast_res = op_a & op_b;
    else if (is_or)     fast_res = op_a | op_b;
    else if (is_add)    fast_res = op_a + op_b;
    else if (is_sub)    fast_res = op_a - op_b;
    else if (is_div_op) fast_res = '1;
    else if (!is_mul)   fast_ill = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; DONE may accept back-to-back.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = multi ? ST_BUSY : ST_DONE;
      ST_BUSY: if (last)   state_nxt = ST_DONE;
      ST_DONE: state_nxt = accept ? (multi ? ST_BUSY : ST_DONE) : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    in_ready = 1'b1;
    done     = 1'b0;
    if (state == ST_BUSY) in_ready = 1'b0;
    if (state == ST_DONE) done     = 1'b1;
  end

  // Operand capture, iteration, and result/flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result  <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvsr    <= '0;
      neg     <= 1'b0;
      is_div  <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
      if (multi) begin
        // Result flags stay put until the iteration completes.
        mcand  <= op_a;
        mplier <= op_b;
        acc    <= '0;
        quo    <= a_mag;
        dvsr   <= b_mag;
        rem    <= '0;
        neg    <= op_a[XLEN-1] ^ op_b[XLEN-1];
        is_div <= is_div_op;
      end else begin
        result  <= fast_res;
        zero    <= (fast_res == '0);
        illegal <= fast_ill;
      end
    end else if (state == ST_BUSY) begin
      cnt    <= cnt + CNT_W'(1);
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_nxt;
      rem    <= rem_nxt;
      quo    <= quo_nxt;
      if (last) begin
        result  <= fin_res;
        zero    <= (fin_res == '0);
        illegal <= 1'b0;
      end
    end
  end

endmodule
